alu_mult_seq: RTL

- Sequential unsigned shift-and-add multiplier that sits directly around the 32-bit ALU adder.
- Feeds the adder's operand inputs (A, B, carry-in) and consumes its sum and carry-out, one add per cycle.
- Produces a 64-bit product after a fixed 32-iteration sequence.
- Gives the ALU a MUL operation without a second adder.

---
 rtl/alu_mult_seq.sv | 109 ++++++++++
 1 files changed

// File: rtl/alu_mult_seq.sv
// Sequential unsigned shift-and-add multiplier built around the shared ALU adder.
// One add per cycle for WIDTH cycles produces a 2*WIDTH-bit product, so the ALU
// gains a MUL operation without a second adder.
module alu_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     adder_inA,
    output logic [WIDTH-1:0]     adder_inB,
    output logic                 cin,
    input  logic [WIDTH-1:0]     sum,
    input  logic                 cout
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;
    logic [WIDTH-1:0] m;
    logic [CW-1:0]    count;
    logic             last_iter;
    logic             accept;

    // A start is only honoured when no multiplication is in flight.
    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_iter = (count == CW'(WIDTH - 1));

    // State register; reset abandons any partial result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: DONE behaves like IDLE for a new start, giving back-to-back ops.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? CALC : IDLE;
            CALC:    state_next = last_iter ? DONE : CALC;
            DONE:    state_next = start ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs and adder drive; the adder sees zeros whenever we are not iterating.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        adder_inA = '0;
        adder_inB = '0;
        cin       = 1'b0;
        case (state)
            CALC: begin
                busy      = 1'b1;
                adder_inA = p_hi;
                adder_inB = p_lo[0] ? m : '0;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Datapath: capture operands on start, then add-and-shift right once per cycle.
    // The adder carry-out lands in the top bit of P_hi so no product bit is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_hi    <= '0;
            p_lo    <= '0;
            m       <= '0;
            count   <= '0;
            product <= '0;
        end else if (accept) begin
            m     <= multiplicand;
            p_hi  <= '0;
            p_lo  <= multiplier;
            count <= '0;
        end else if (state == CALC) begin
            p_hi  <= {cout, sum[WIDTH-1:1]};
            p_lo  <= {sum[0], p_lo[WIDTH-1:1]};
            count <= count + 1'b1;
            if (last_iter) begin
                product <= {cout, sum, p_lo[WIDTH-1:1]};
            end
        end
    end

endmodule
